// File: rtl/axil_master_wrapper.sv
// Command-driven AXI4-Lite master wired to an internal AXI4-Lite register-file slave.
// One transaction is in flight at a time; so_valid pulses when it completes.
module axil_master_wrapper #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  si_valid,
  input  logic                  si_write,
  input  logic [ADDR_WIDTH-1:0] si_addr,
  input  logic [DATA_WIDTH-1:0] si_data,
  output logic                  so_ready,
  output logic                  so_valid,
  output logic [DATA_WIDTH-1:0] so_data,
  output logic [1:0]            so_resp
);

  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   data_reg;
  logic                    aw_done_reg, w_done_reg;
  logic [DATA_WIDTH-1:0]   so_data_reg;
  logic [1:0]              so_resp_reg;

  // Internal AXI-Lite channels
  logic                    awvalid, wvalid, bready, arvalid, rready;
  logic [STRB_WIDTH-1:0]   wstrb;
  logic                    wr_ready_reg, ar_ready_reg;
  logic                    bvalid_reg, rvalid_reg;
  logic [1:0]              bresp_reg, rresp_reg;
  logic [DATA_WIDTH-1:0]   rdata_reg;
  logic [DATA_WIDTH-1:0]   mem_reg [DEPTH];

  logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_en;

  assign accept = si_valid & so_ready;
  assign aw_hs  = awvalid & wr_ready_reg;
  assign w_hs   = wvalid & wr_ready_reg;
  assign b_hs   = bvalid_reg & bready;
  assign ar_hs  = arvalid & ar_ready_reg;
  assign r_hs   = rvalid_reg & rready;
  assign wr_en  = aw_hs & w_hs;

  // ---------------- master FSM ----------------
  always_ff @(posedge clk) begin
    if (nreset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    so_ready   = 1'b0;
    so_valid   = 1'b0;
    awvalid    = 1'b0;
    wvalid     = 1'b0;
    wstrb      = '1;
    bready     = 1'b0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    case (state_reg)
      IDLE: begin
        so_ready = 1'b1;
        if (si_valid) state_next = si_write ? WR_REQ : RD_REQ;
      end
      WR_REQ: begin
        awvalid = ~aw_done_reg;
        wvalid  = ~w_done_reg;
        if ((aw_done_reg | aw_hs) && (w_done_reg | w_hs)) state_next = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (b_hs) state_next = DONE;
      end
      RD_REQ: begin
        arvalid = 1'b1;
        if (ar_hs) state_next = RD_RESP;
      end
      RD_RESP: begin
        rready = 1'b1;
        if (r_hs) state_next = DONE;
      end
      DONE: begin
        so_valid   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      addr_reg    <= '0;
      data_reg    <= '0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      so_data_reg <= '0;
      so_resp_reg <= 2'b00;
    end else begin
      if (accept) begin
        addr_reg <= si_addr;
        data_reg <= si_data;
      end
      // Per-channel completion flags let AW and W handshake independently
      if (state_reg == IDLE) begin
        aw_done_reg <= 1'b0;
        w_done_reg  <= 1'b0;
      end else begin
        if (aw_hs) aw_done_reg <= 1'b1;
        if (w_hs)  w_done_reg  <= 1'b1;
      end
      if (b_hs) so_resp_reg <= bresp_reg;
      if (r_hs) begin
        so_data_reg <= rdata_reg;
        so_resp_reg <= rresp_reg;
      end
    end
  end

  assign so_data = so_data_reg;
  assign so_resp = so_resp_reg;

  // ---------------- slave register file ----------------
  always_ff @(posedge clk) begin
    if (nreset) begin
      wr_ready_reg <= 1'b0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= 2'b00;
      ar_ready_reg <= 1'b0;
      rvalid_reg   <= 1'b0;
      rresp_reg    <= 2'b00;
      rdata_reg    <= '0;
    end else begin
      // Ready is a single-cycle pulse raised the cycle after the valids appear
      wr_ready_reg <= ~wr_ready_reg & awvalid & wvalid & ~bvalid_reg;
      ar_ready_reg <= ~ar_ready_reg & arvalid & ~rvalid_reg;
      if (wr_en) begin
        bvalid_reg <= 1'b1;
        bresp_reg  <= 2'b00;
      end else if (b_hs) begin
        bvalid_reg <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= mem_reg[addr_reg];
        rresp_reg  <= 2'b00;
      end else if (r_hs) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (nreset) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wstrb[b]) mem_reg[addr_reg][b*8 +: 8] <= data_reg[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axil_master_wrapper.sv
// Scoreboard bench for axil_master_wrapper: a reference memory predicts each
// completion, which is queued at accept and compared when so_valid pulses.
module tb_axil_master_wrapper;

  logic        clk = 1'b0;
  logic        nreset;
  logic        si_valid, si_write;
  logic [7:0]  si_addr;
  logic [31:0] si_data;
  logic        so_ready, so_valid;
  logic [31:0] so_data;
  logic [1:0]  so_resp;

  axil_master_wrapper #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk(clk), .nreset(nreset),
    .si_valid(si_valid), .si_write(si_write), .si_addr(si_addr), .si_data(si_data),
    .so_ready(so_ready), .so_valid(so_valid), .so_data(so_data), .so_resp(so_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_write;
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model [256];
  logic [31:0] last_rd;
  int          checks = 0;
  int          errors = 0;
  int          pulse_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: one pop per so_valid cycle
  always @(negedge clk) begin
    if (!nreset && so_valid) begin
      exp_t e;
      pulse_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_so_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk(e.is_write ? "wr_resp" : "rd_resp", {30'd0, so_resp}, 32'd0);
        if (e.is_write) begin
          chk("wr_data_hold", so_data, e.data);
          $display("WRITE addr=%02h data=%08h resp=%0d", e.addr, si_data, so_resp);
        end else begin
          chk("rd_data", so_data, e.data);
          $display("READ  addr=%02h data=%08h resp=%0d", e.addr, so_data, so_resp);
        end
      end
    end
  end

  // Drive a command, wait (bounded) for acceptance; wait_cycles counts busy negedges.
  task automatic send(input bit wr, input logic [7:0] a, input logic [31:0] d,
                      input bit track, output int wait_cycles);
    exp_t e;
    @(negedge clk);
    si_valid = 1'b1; si_write = wr; si_addr = a; si_data = d;
    wait_cycles = 0;
    while (!so_ready && wait_cycles < 50) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (!so_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else if (track) begin
      e.is_write = wr;
      e.addr     = a;
      if (wr) begin
        model[a] = d;
        e.data   = last_rd;
      end else begin
        e.data  = model[a];
        last_rd = model[a];
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1 si_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(negedge clk);
    nreset = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 32'd0;
    last_rd = 32'd0;
  endtask

  initial begin
    int w;
    int pulses_before;
    nreset = 1'b1; si_valid = 1'b0; si_write = 1'b0; si_addr = '0; si_data = '0;
    for (int i = 0; i < 256; i++) model[i] = 32'd0;
    last_rd = 32'd0;
    repeat (3) @(negedge clk);
    nreset = 1'b0;
    @(negedge clk);
    chk("rst_so_ready", {31'd0, so_ready}, 32'd1);
    chk("rst_so_valid", {31'd0, so_valid}, 32'd0);
    chk("rst_so_data", so_data, 32'd0);
    chk("rst_so_resp", {30'd0, so_resp}, 32'd0);
    send(1'b0, 8'h00, 32'd0, 1'b1, w);
    drain();

    // Write/read at a high index, back-to-back to measure turnaround
    send(1'b1, 8'hF3, 32'hB4B4B4B4, 1'b1, w);
    send(1'b0, 8'hF3, 32'd0, 1'b1, w);
    chk("wr_to_rd_turnaround", w, 32'd4);
    drain();

    // Isolation between neighbouring / extreme addresses
    send(1'b1, 8'h00, 32'h11111111, 1'b1, w);
    send(1'b1, 8'hFF, 32'hFFFFFFFF, 1'b1, w);
    send(1'b0, 8'h01, 32'd0, 1'b1, w);
    send(1'b0, 8'h00, 32'd0, 1'b1, w);
    send(1'b0, 8'hFF, 32'd0, 1'b1, w);
    drain();

    // Busy: second command held while a read is in flight
    send(1'b0, 8'hF3, 32'd0, 1'b1, w);
    send(1'b1, 8'h10, 32'hDEADBEEF, 1'b1, w);
    chk("busy_accept_delay", w, 32'd4);
    send(1'b0, 8'h10, 32'd0, 1'b1, w);
    drain();

    // Reset in the middle of a write
    send(1'b1, 8'h20, 32'h12345678, 1'b1, w);
    drain();
    pulses_before = pulse_cnt;
    send(1'b1, 8'h20, 32'hCAFEF00D, 1'b0, w);
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    nreset = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 32'd0;
    last_rd = 32'd0;
    repeat (6) @(negedge clk);
    chk("midrst_no_pulse", pulse_cnt, pulses_before);
    chk("midrst_so_ready", {31'd0, so_ready}, 32'd1);
    chk("midrst_so_data", so_data, 32'd0);
    send(1'b0, 8'h20, 32'd0, 1'b1, w);
    send(1'b0, 8'hF3, 32'd0, 1'b1, w);
    drain();

    // Overwrite
    send(1'b1, 8'h05, 32'h00000001, 1'b1, w);
    send(1'b1, 8'h05, 32'h00000002, 1'b1, w);
    send(1'b0, 8'h05, 32'd0, 1'b1, w);
    drain();

    // A few random transactions against the reference model
    for (int k = 0; k < 12; k++) begin
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), $urandom, 1'b1, w);
    end
    drain();
    do_reset();
    chk("final_rst_so_data", so_data, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
